// File: rtl/cnt_seg_display_if.sv
// -----------------------------------------------------------------------------
// cnt_seg_display_if
//
// Bundles the counter-side inputs and the display/wrap-monitor outputs of
// cnt_seg_display.
//   count[3:0]     counter value from the upstream 4-bit counter
//   hold           1 = freeze the displayed value (wrap detection continues)
//   wrap_clr       synchronous clear of wrap_cnt
//   seg[6:0]       segment drive, active-low, seg[0]=a .. seg[6]=g
//   dp             decimal point, active-low
//   an[1:0]        digit enables, active-low, an[0]=ones, an[1]=tens
//   wrap_pulse     one-cycle pulse on a detected 15->0 wrap
//   wrap_cnt[3:0]  saturating wrap count
// master = counter/board side, slave = display stage.
// -----------------------------------------------------------------------------
interface cnt_seg_display_if;
   logic [3:0] count;
   logic       hold;
   logic       wrap_clr;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] an;
   logic       wrap_pulse;
   logic [3:0] wrap_cnt;

   modport master (
      output count, hold, wrap_clr,
      input  seg, dp, an, wrap_pulse, wrap_cnt
   );

   modport slave (
      input  count, hold, wrap_clr,
      output seg, dp, an, wrap_pulse, wrap_cnt
   );
endinterface

// File: rtl/cnt_seg_display.sv
// -----------------------------------------------------------------------------
// cnt_seg_display
//
// Samples a free-running 4-bit counter, splits the sample into decimal
// tens/ones and drives a two-digit, time-multiplexed common-anode
// seven-segment display. Also detects 15->0 wraps of the counter and counts
// them in a saturating 4-bit register.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    cnt_seg_display_if.slave (count/hold/wrap_clr in,
//          seg/dp/an/wrap_pulse/wrap_cnt out)
// Parameter:
//   SCAN_DIV  cycles each digit stays enabled (>= 2)
// All outputs are registered; there is no input-to-output combinational path.
// -----------------------------------------------------------------------------
module cnt_seg_display #(
   parameter int SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              reset,
   cnt_seg_display_if.slave  bus
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   // Digit-select encoding
   localparam logic SEL_ONES = 1'b0;
   localparam logic SEL_TENS = 1'b1;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic [3:0]       count_q, count_d;
   logic [3:0]       prev_q, prev_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             sel_q, sel_d;
   logic             wrap_pulse_q, wrap_pulse_d;
   logic [3:0]       wrap_cnt_q, wrap_cnt_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       an_q, an_d;
   logic             dp_q, dp_d;

   logic             wrap;
   logic             tens;
   logic [3:0]       ones;

   // Active-low segment pattern, g..a, for a decimal digit
   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    seg_enc = 7'b1000000;
         4'd1:    seg_enc = 7'b1111001;
         4'd2:    seg_enc = 7'b0100100;
         4'd3:    seg_enc = 7'b0110000;
         4'd4:    seg_enc = 7'b0011001;
         4'd5:    seg_enc = 7'b0010010;
         4'd6:    seg_enc = 7'b0000010;
         4'd7:    seg_enc = 7'b1111000;
         4'd8:    seg_enc = 7'b0000000;
         4'd9:    seg_enc = 7'b0010000;
         default: seg_enc = SEG_BLANK;
      endcase
   endfunction

   always_comb begin
      // NOTE: every signal gets a value before any branch so no latch can be
      // inferred.
      count_d      = bus.hold ? count_q : bus.count;
      prev_d       = bus.count;

      // History is taken regardless of hold, so wraps are seen while frozen
      wrap         = (prev_q == 4'hF) && (bus.count == 4'h0);
      wrap_pulse_d = wrap;

      wrap_cnt_d   = wrap_cnt_q;
      if (bus.wrap_clr)
         wrap_cnt_d = 4'd0;                 // clear beats a coincident wrap
      else if (wrap && (wrap_cnt_q != 4'hF))
         wrap_cnt_d = wrap_cnt_q + 4'd1;

      // count_q <= 15, so subtracting 10 only happens when it cannot underflow
      tens = (count_q >= 4'd10);
      ones = tens ? (count_q - 4'd10) : count_q;

      div_d = div_q + DIV_W'(1);
      sel_d = sel_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         sel_d = ~sel_q;
      end

      // Display registers follow sel_q, so an lags sel by one edge
      if (sel_q == SEL_TENS) begin
         an_d  = 2'b01;
         seg_d = tens ? seg_enc(4'd1) : SEG_BLANK;  // leading-zero blanking
      end else begin
         an_d  = 2'b10;
         seg_d = seg_enc(ones);
      end

      // Decimal point marks a frozen display, shown on the ones digit only
      dp_d = ~((sel_q == SEL_ONES) && bus.hold);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // from the same pre-edge values; the asynchronous reset covers every flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q      <= 4'd0;
         prev_q       <= 4'd0;
         div_q        <= '0;
         sel_q        <= SEL_ONES;
         wrap_pulse_q <= 1'b0;
         wrap_cnt_q   <= 4'd0;
         seg_q        <= 7'b1000000;
         an_q         <= 2'b10;
         dp_q         <= 1'b1;
      end else begin
         count_q      <= count_d;
         prev_q       <= prev_d;
         div_q        <= div_d;
         sel_q        <= sel_d;
         wrap_pulse_q <= wrap_pulse_d;
         wrap_cnt_q   <= wrap_cnt_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         dp_q         <= dp_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.dp         = dp_q;
   assign bus.wrap_pulse = wrap_pulse_q;
   assign bus.wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_cnt_seg_display.sv
// -----------------------------------------------------------------------------
// tb_cnt_seg_display
//
// Directed self-checking bench for cnt_seg_display with SCAN_DIV=4.
// n_edge counts rising edges since the last reset release; the expected digit
// select for the registered display after edge n is ((n-1)/4)%2.
// -----------------------------------------------------------------------------
module tb_cnt_seg_display;

   localparam int SD = 4;

   logic clk;
   logic reset;
   int   n_edge;
   int   n_checks;
   int   n_pass;

   logic [6:0] enc_tab [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   cnt_seg_display_if bus ();

   cnt_seg_display #(.SCAN_DIV(SD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // One rising edge, then settle before sampling/driving
   task automatic step();
      @(posedge clk);
      #1;
      n_edge++;
   endtask

   // Expected an/seg for a value that has been stable for at least two edges
   task automatic check_display(input string tag, input int val);
      int         sp;
      int         ones;
      logic       tens;
      logic [1:0] ae;
      logic [6:0] se;
      sp   = (n_edge == 0) ? 0 : ((n_edge - 1) / SD) % 2;
      tens = (val >= 10);
      ones = tens ? val - 10 : val;
      ae   = (sp == 1) ? 2'b01 : 2'b10;
      se   = (sp == 1) ? (tens ? enc_tab[1] : 7'b1111111) : enc_tab[ones];
      check({tag, "_an"}, {30'd0, bus.an}, {30'd0, ae});
      check({tag, "_seg"}, {25'd0, bus.seg}, {25'd0, se});
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset  = 1'b1;
      n_edge = 0;
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      n_edge       = 0;
      reset        = 1'b1;
      bus.count    = 4'd7;
      bus.hold     = 1'b0;
      bus.wrap_clr = 1'b0;

      // ---- reset state ----
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_seg", bus.seg, 7'b1000000);
      check("rst_an", bus.an, 2'b10);
      check("rst_dp", bus.dp, 1'b1);
      check("rst_wcnt", bus.wrap_cnt, 4'd0);
      check("rst_wpulse", bus.wrap_pulse, 1'b0);

      release_reset();
      step();
      step();
      check("lat_seg7", bus.seg, 7'b1111000);
      check("lat_an", bus.an, 2'b10);

      // ---- 13 held steady: ones shows 3, tens shows 1 ----
      bus.count = 4'd13;
      step();
      step();
      check("d13_ones_seg", bus.seg, 7'b0110000);   // n=4, sel after edge 3 = 0
      step();
      check("d13_tens_seg", bus.seg, 7'b1111001);   // n=5, sel after edge 4 = 1
      check("d13_tens_an", bus.an, 2'b01);
      for (int i = 0; i < 10; i++) begin
         step();
         check_display("d13", 13);
         check("d13_dp", bus.dp, 1'b1);
      end

      // ---- 5: tens digit blanked ----
      bus.count = 4'd5;
      step();
      step();
      for (int i = 0; i < 8; i++) begin
         step();
         check_display("d5", 5);
      end

      // ---- 14,15,0,1 sweep: one wrap ----
      bus.count = 4'd14; step();
      check("sw14_pulse", bus.wrap_pulse, 1'b0);
      bus.count = 4'd15; step();
      check("sw15_pulse", bus.wrap_pulse, 1'b0);
      check("sw15_wcnt", bus.wrap_cnt, 4'd0);
      bus.count = 4'd0;  step();
      check("sw0_pulse", bus.wrap_pulse, 1'b1);
      check("sw0_wcnt", bus.wrap_cnt, 4'd1);
      bus.count = 4'd1;  step();
      check("sw1_pulse", bus.wrap_pulse, 1'b0);
      check("sw1_wcnt", bus.wrap_cnt, 4'd1);

      // ---- 16 further wraps: saturate at 15 ----
      for (int k = 1; k <= 16; k++) begin
         bus.count = 4'd15; step();
         check("sat_nopulse", bus.wrap_pulse, 1'b0);
         bus.count = 4'd0;  step();
         check("sat_pulse", bus.wrap_pulse, 1'b1);
         check("sat_wcnt", bus.wrap_cnt, (k + 1 > 15) ? 32'd15 : 32'(k + 1));
      end

      // ---- clear, build to 6, then clear coincident with a wrap ----
      bus.wrap_clr = 1'b1; step();
      bus.wrap_clr = 1'b0;
      check("clr_wcnt", bus.wrap_cnt, 4'd0);
      for (int k = 0; k < 6; k++) begin
         bus.count = 4'd15; step();
         bus.count = 4'd0;  step();
      end
      check("six_wcnt", bus.wrap_cnt, 4'd6);
      bus.count = 4'd15; step();
      bus.count = 4'd0;
      bus.wrap_clr = 1'b1; step();
      bus.wrap_clr = 1'b0;
      check("clrwrap_pulse", bus.wrap_pulse, 1'b1);
      check("clrwrap_wcnt", bus.wrap_cnt, 4'd0);

      // ---- hold at 9 while count moves to 12 ----
      bus.count = 4'd9; step(); step();
      bus.hold  = 1'b1;
      bus.count = 4'd12;
      for (int i = 0; i < 8; i++) begin
         step();
         check_display("hold9", 9);
         check("hold_dp", bus.dp,
               (((n_edge - 1) / SD) % 2 == 0) ? 1'b0 : 1'b1);
      end
      bus.hold = 1'b0;
      step();
      step();
      check_display("rel12", 12);
      check("rel_dp", bus.dp, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check_display("rel12b", 12);
      end

      // ---- reset asserted mid-pulse ----
      bus.count = 4'd15; step();
      bus.count = 4'd0;  step();
      check("pre_rst_pulse", bus.wrap_pulse, 1'b1);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_pulse", bus.wrap_pulse, 1'b0);
      check("mid_rst_wcnt", bus.wrap_cnt, 4'd0);
      check("mid_rst_seg", bus.seg, 7'b1000000);
      check("mid_rst_an", bus.an, 2'b10);
      check("mid_rst_dp", bus.dp, 1'b1);
      release_reset();
      for (int i = 0; i < 12; i++) begin
         step();
         check_display("post_rst", 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
